// File: rtl/uart_tx_framed.sv
// -----------------------------------------------------------------------------
// uart_tx_framed
//
// Serial transmitter with a small write FIFO and a per-frame configurable
// format: 5 to 8 data bits, optional even/odd parity and one or two stop bits.
// Every bit on the line (start, data, parity, stop) lasts max(cyclesPerBit,1)
// clocks. The frame format is captured when a frame starts, so changing the
// configuration inputs mid-frame only affects the following frame.
//
// Parameters
//   CLOCK_SCALE_BITS  width of the baud divider / cyclesPerBit
//   FIFO_DEPTH_LOG2   FIFO holds 2**FIFO_DEPTH_LOG2 bytes (1..6)
//
// Ports
//   clk               clock, all logic on the rising edge
//   rst               synchronous active-high reset
//   cyclesPerBit      clocks per bit; 0 behaves like 1
//   dataBits          00=5, 01=6, 10=7, 11=8 data bits
//   parityMode        00=none, 01=even, 10=odd, 11=none
//   twoStopBits       0=one stop bit, 1=two stop bits
//   dataIn            byte to queue (only the low data bits are sent)
//   dataWrite         write strobe, one byte per asserted cycle
//   blockTransmition  holds off the start of a new frame while high
//   tx                registered serial output, idles high
//   busy              frame in flight or FIFO non-empty
//   fifoFull          FIFO is at capacity
//   fifoCount         FIFO occupancy
//   overflow          one-cycle pulse after a write was dropped
// -----------------------------------------------------------------------------
module uart_tx_framed #(
    parameter int CLOCK_SCALE_BITS = 16,
    parameter int FIFO_DEPTH_LOG2  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
    input  logic [1:0]                  dataBits,
    input  logic [1:0]                  parityMode,
    input  logic                        twoStopBits,
    input  logic [7:0]                  dataIn,
    input  logic                        dataWrite,
    input  logic                        blockTransmition,
    output logic                        tx,
    output logic                        busy,
    output logic                        fifoFull,
    output logic [FIFO_DEPTH_LOG2:0]    fifoCount,
    output logic                        overflow
);

    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } stateType;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    stateType                       stateReg,       stateNext;
    logic [CLOCK_SCALE_BITS-1:0]    divReg,         divNext;
    logic [2:0]                     bitCntReg,      bitCntNext;
    logic                           txReg,          txNext;
    logic                           busyReg,        busyNext;
    logic                           overflowReg,    overflowNext;
    logic [FIFO_DEPTH_LOG2:0]       countReg,       countNext;
    logic [FIFO_DEPTH_LOG2-1:0]     wrPtrReg;
    logic [FIFO_DEPTH_LOG2-1:0]     rdPtrReg;

    // Frame format captured at frame start
    logic [1:0]                     frameBitsReg,    frameBitsNext;
    logic [1:0]                     frameParityReg,  frameParityNext;
    logic                           frameTwoStopReg, frameTwoStopNext;

    // Byte being transmitted, loaded straight from the FIFO array on a pop
    logic [7:0]                     frameDataReg;
    logic [7:0]                     fifoMem [FIFO_DEPTH];

    // -------------------------------------------------------------------------
    // Derived control
    // -------------------------------------------------------------------------
    logic [CLOCK_SCALE_BITS-1:0]    bitPeriodLast;
    logic                           bitDone;
    logic                           wrEn;
    logic                           pop;
    logic                           startOk;
    logic                           startFrame;
    logic [2:0]                     lastIdx;
    logic [2:0]                     nextBitIdx;
    logic                           parityOn;
    logic                           parityBit;
    logic [7:0]                     dataMask;

    // A divisor of 0 is treated as 1, so the last divider value is 0 either way.
    assign bitPeriodLast = (cyclesPerBit == '0) ? '0 : cyclesPerBit - CLOCK_SCALE_BITS'(1);

    // ">=" keeps the bit ending even if cyclesPerBit shrinks below the
    // current divider value during a frame.
    assign bitDone    = (divReg >= bitPeriodLast);

    assign fifoFull   = (countReg == FULL_COUNT);
    assign wrEn       = dataWrite && !fifoFull;
    assign startOk    = (countReg != '0) && !blockTransmition;

    // Index of the last data bit: 5 bits -> 4, ..., 8 bits -> 7
    assign lastIdx    = {1'b1, frameBitsReg};
    assign nextBitIdx = bitCntReg + 3'd1;

    assign parityOn   = (frameParityReg == 2'b01) || (frameParityReg == 2'b10);

    // Mask of the data bits that actually go on the line for this frame
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : gen_data_mask
            assign dataMask[gi] = (3'(gi) <= lastIdx);
        end
    endgenerate

    // Even parity = XOR of sent bits; odd parity inverts it
    assign parityBit = (^(frameDataReg & dataMask)) ^ (frameParityReg == 2'b10);

    // -------------------------------------------------------------------------
    // FIFO storage: array without reset so it maps onto RAM; the read is
    // registered directly into the frame data register on a pop.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wrEn) begin
            fifoMem[wrPtrReg] <= dataIn;
        end
        if (pop) begin
            frameDataReg <= fifoMem[rdPtrReg];
        end
    end

    // -------------------------------------------------------------------------
    // FIFO occupancy and status
    // -------------------------------------------------------------------------
    always_comb begin
        countNext = countReg;
        case ({wrEn, pop})
            2'b10:   countNext = countReg + (FIFO_DEPTH_LOG2 + 1)'(1);
            2'b01:   countNext = countReg - (FIFO_DEPTH_LOG2 + 1)'(1);
            default: countNext = countReg;
        endcase
    end

    // A write against a full FIFO is dropped even if a pop frees a slot on
    // the same edge, since acceptance is judged on the registered full flag.
    assign overflowNext = dataWrite && fifoFull;

    // -------------------------------------------------------------------------
    // FSM next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        stateNext        = stateReg;
        divNext          = divReg + CLOCK_SCALE_BITS'(1);
        bitCntNext       = bitCntReg;
        txNext           = txReg;
        frameBitsNext    = frameBitsReg;
        frameParityNext  = frameParityReg;
        frameTwoStopNext = frameTwoStopReg;
        startFrame       = 1'b0;

        case (stateReg)
            IDLE: begin
                divNext = '0;
                txNext  = 1'b1;
                if (startOk) begin
                    startFrame = 1'b1;
                end
            end

            START: begin
                if (bitDone) begin
                    divNext    = '0;
                    bitCntNext = 3'd0;
                    txNext     = frameDataReg[0];
                    stateNext  = DATA;
                end
            end

            DATA: begin
                if (bitDone) begin
                    divNext = '0;
                    if (bitCntReg == lastIdx) begin
                        bitCntNext = 3'd0;
                        if (parityOn) begin
                            txNext    = parityBit;
                            stateNext = PARITY;
                        end else begin
                            txNext    = 1'b1;
                            stateNext = STOP;
                        end
                    end else begin
                        bitCntNext = nextBitIdx;
                        txNext     = frameDataReg[nextBitIdx];
                    end
                end
            end

            PARITY: begin
                if (bitDone) begin
                    divNext    = '0;
                    bitCntNext = 3'd0;
                    txNext     = 1'b1;
                    stateNext  = STOP;
                end
            end

            STOP: begin
                if (bitDone) begin
                    divNext = '0;
                    txNext  = 1'b1;
                    // bitCnt counts elapsed stop periods here
                    if (frameTwoStopReg && (bitCntReg == 3'd0)) begin
                        bitCntNext = 3'd1;
                    end else if (startOk) begin
                        // Chain straight into the next start bit, no idle gap
                        startFrame = 1'b1;
                    end else begin
                        bitCntNext = 3'd0;
                        stateNext  = IDLE;
                    end
                end
            end

            default: begin
                divNext    = '0;
                bitCntNext = 3'd0;
                txNext     = 1'b1;
                stateNext  = IDLE;
            end
        endcase

        // Frame start: pop, capture the format and drive the start bit
        if (startFrame) begin
            stateNext        = START;
            txNext           = 1'b0;
            divNext          = '0;
            bitCntNext       = 3'd0;
            frameBitsNext    = dataBits;
            frameParityNext  = parityMode;
            frameTwoStopNext = twoStopBits;
        end
    end

    assign pop      = startFrame;
    assign busyNext = (stateNext != IDLE) || (countNext != '0);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg        <= IDLE;
            divReg          <= '0;
            bitCntReg       <= 3'd0;
            txReg           <= 1'b1;
            busyReg         <= 1'b0;
            overflowReg     <= 1'b0;
            countReg        <= '0;
            wrPtrReg        <= '0;
            rdPtrReg        <= '0;
            frameBitsReg    <= 2'b11;
            frameParityReg  <= 2'b00;
            frameTwoStopReg <= 1'b0;
        end else begin
            stateReg        <= stateNext;
            divReg          <= divNext;
            bitCntReg       <= bitCntNext;
            txReg           <= txNext;
            busyReg         <= busyNext;
            overflowReg     <= overflowNext;
            countReg        <= countNext;
            frameBitsReg    <= frameBitsNext;
            frameParityReg  <= frameParityNext;
            frameTwoStopReg <= frameTwoStopNext;
            if (wrEn) begin
                wrPtrReg <= wrPtrReg + FIFO_DEPTH_LOG2'(1);
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + FIFO_DEPTH_LOG2'(1);
            end
        end
    end

    assign tx        = txReg;
    assign busy      = busyReg;
    assign fifoCount = countReg;
    assign overflow  = overflowReg;

endmodule

// File: tb/tb_uart_tx_framed.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_framed: a table of single-frame vectors with
// hand-computed line waveforms, followed by hand-written multi-cycle
// sequences for FIFO overflow, back-to-back frames, mid-frame configuration
// changes, mid-frame reset and simultaneous write/pop.
// -----------------------------------------------------------------------------
module tb_uart_tx_framed;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cyclesPerBit;
    logic [1:0]  dataBits;
    logic [1:0]  parityMode;
    logic        twoStopBits;
    logic [7:0]  dataIn;
    logic        dataWrite;
    logic        blockTransmition;
    logic        tx;
    logic        busy;
    logic        fifoFull;
    logic [2:0]  fifoCount;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_framed #(
        .CLOCK_SCALE_BITS (16),
        .FIFO_DEPTH_LOG2  (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cyclesPerBit     (cyclesPerBit),
        .dataBits         (dataBits),
        .parityMode       (parityMode),
        .twoStopBits      (twoStopBits),
        .dataIn           (dataIn),
        .dataWrite        (dataWrite),
        .blockTransmition (blockTransmition),
        .tx               (tx),
        .busy             (busy),
        .fifoFull         (fifoFull),
        .fifoCount        (fifoCount),
        .overflow         (overflow)
    );

    // One frame: configuration, byte, and the expected line waveform written
    // in transmit order (start bit is the leftmost of the len bits).
    typedef struct {
        logic [15:0] cpb;
        logic [1:0]  bits;
        logic [1:0]  par;
        logic        stop2;
        logic [7:0]  data;
        logic [15:0] frame;
        int          len;
        int          n;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Samples tx once per clock; the first tick must be the start-bit edge.
    task automatic checkFrame(input logic [15:0] frame, input int len, input int n, input string name);
        for (int b = 0; b < len; b++) begin
            logic want;
            logic got;
            want = frame[len - 1 - b];
            got  = want;
            for (int c = 0; c < n; c++) begin
                tick();
                if ((tx !== want) && (got === want)) got = tx;
            end
            check($sformatf("%s bit%0d", name, b), 32'(got), 32'(want));
        end
    endtask

    task automatic writeByte(input logic [7:0] d);
        dataIn    = d;
        dataWrite = 1'b1;
        tick();
        dataWrite = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovCount;
        logic txStayedHigh;

        //           cpb    bits   par    stop2 data   frame (transmit order)    len n
        vecs[0] = '{16'd4, 2'b11, 2'b00, 1'b0, 8'h55, 16'b0101010101,        10, 4};
        vecs[1] = '{16'd3, 2'b10, 2'b01, 1'b1, 8'h41, 16'b01000001011,       11, 3};
        vecs[2] = '{16'd3, 2'b10, 2'b10, 1'b1, 8'h41, 16'b01000001111,       11, 3};
        vecs[3] = '{16'd2, 2'b00, 2'b00, 1'b0, 8'h13, 16'b0110011,           7,  2};
        vecs[4] = '{16'd1, 2'b01, 2'b11, 1'b0, 8'h2D, 16'b01011011,          8,  1};
        vecs[5] = '{16'd2, 2'b11, 2'b10, 1'b0, 8'hFF, 16'b01111111111,       11, 2};
        vecs[6] = '{16'd0, 2'b11, 2'b00, 1'b1, 8'hF0, 16'b00000111111,       11, 1};
        vecs[7] = '{16'd5, 2'b00, 2'b01, 1'b0, 8'h07, 16'b01110011,          8,  5};

        rst              = 1'b1;
        cyclesPerBit     = 16'd4;
        dataBits         = 2'b11;
        parityMode       = 2'b00;
        twoStopBits      = 1'b0;
        dataIn           = 8'h00;
        dataWrite        = 1'b0;
        blockTransmition = 1'b0;
        repeat (3) tick();

        check("reset tx",        32'(tx),        32'd1);
        check("reset busy",      32'(busy),      32'd0);
        check("reset fifoFull",  32'(fifoFull),  32'd0);
        check("reset fifoCount", 32'(fifoCount), 32'd0);
        check("reset overflow",  32'(overflow),  32'd0);
        rst = 1'b0;
        tick();
        $display("reset: tx=%0b busy=%0b count=%0d", tx, busy, fifoCount);

        // ---------------- table-driven single frames ----------------
        for (int i = 0; i < 8; i++) begin
            cyclesPerBit = vecs[i].cpb;
            dataBits     = vecs[i].bits;
            parityMode   = vecs[i].par;
            twoStopBits  = vecs[i].stop2;
            writeByte(vecs[i].data);
            // Write seen at edge k: queued, tx still high until edge k+1
            check($sformatf("vec%0d latency tx", i),    32'(tx),        32'd1);
            check($sformatf("vec%0d queued count", i),  32'(fifoCount), 32'd1);
            check($sformatf("vec%0d queued busy", i),   32'(busy),      32'd1);
            checkFrame(vecs[i].frame, vecs[i].len, vecs[i].n, $sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d end busy", i),  32'(busy),      32'd0);
            check($sformatf("vec%0d end tx", i),    32'(tx),        32'd1);
            check($sformatf("vec%0d end count", i), 32'(fifoCount), 32'd0);
            $display("frame vec%0d data=%02h cpb=%0d bits=%0b par=%0b stop2=%0b done", i,
                     vecs[i].data, vecs[i].cpb, vecs[i].bits, vecs[i].par, vecs[i].stop2);
        end

        // ---------------- overflow with block, then back-to-back drain ----------------
        cyclesPerBit     = 16'd2;
        dataBits         = 2'b11;
        parityMode       = 2'b00;
        twoStopBits      = 1'b0;
        blockTransmition = 1'b1;
        ovCount          = 0;
        txStayedHigh     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dataIn    = 8'(8'hA0 + i);
            dataWrite = 1'b1;
            tick();
            if (overflow === 1'b1) ovCount++;
            if (tx !== 1'b1) txStayedHigh = 1'b0;
        end
        dataWrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (overflow === 1'b1) ovCount++;
            if (tx !== 1'b1) txStayedHigh = 1'b0;
        end
        check("ovf pulse count", 32'(ovCount),      32'd1);
        check("ovf fifoCount",   32'(fifoCount),    32'd4);
        check("ovf fifoFull",    32'(fifoFull),     32'd1);
        check("ovf tx high",     32'(txStayedHigh), 32'd1);
        check("ovf busy",        32'(busy),         32'd1);
        blockTransmition = 1'b0;
        checkFrame(16'b0000001011, 10, 2, "b2b A0");
        checkFrame(16'b0100001011, 10, 2, "b2b A1");
        checkFrame(16'b0010001011, 10, 2, "b2b A2");
        checkFrame(16'b0110001011, 10, 2, "b2b A3");
        tick();
        check("b2b end busy", 32'(busy), 32'd0);
        $display("overflow/back-to-back: pulses=%0d, A0..A3 drained", ovCount);

        // ---------------- mid-frame config change and block ----------------
        blockTransmition = 1'b1;
        writeByte(8'h96);
        writeByte(8'h3C);
        blockTransmition = 1'b0;
        fork
            begin
                checkFrame(16'b0011010011, 10, 2, "cfg 8bit");
                checkFrame(16'b0001111,    7,  2, "cfg 5bit");
            end
            begin
                repeat (5) tick();
                dataBits = 2'b00;
                repeat (20) tick();
                blockTransmition = 1'b1;
                dataIn    = 8'h0B;
                dataWrite = 1'b1;
                tick();
                dataWrite = 1'b0;
            end
        join
        txStayedHigh = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tx !== 1'b1) txStayedHigh = 1'b0;
        end
        check("block held tx",    32'(txStayedHigh), 32'd1);
        check("block held count", 32'(fifoCount),    32'd1);
        check("block held busy",  32'(busy),         32'd1);
        blockTransmition = 1'b0;
        checkFrame(16'b0110101, 7, 2, "cfg after block");
        tick();
        check("cfg end busy", 32'(busy), 32'd0);
        $display("config change / mid-frame block sequence done");

        // ---------------- reset during DATA ----------------
        cyclesPerBit     = 16'd4;
        dataBits         = 2'b11;
        blockTransmition = 1'b1;
        writeByte(8'h00);
        writeByte(8'h12);
        blockTransmition = 1'b0;
        repeat (6) tick();
        check("prerst tx data0", 32'(tx),        32'd0);
        check("prerst count",    32'(fifoCount), 32'd1);
        rst = 1'b1;
        tick();
        check("rst tx",       32'(tx),        32'd1);
        check("rst busy",     32'(busy),      32'd0);
        check("rst count",    32'(fifoCount), 32'd0);
        check("rst overflow", 32'(overflow),  32'd0);
        rst = 1'b0;
        cyclesPerBit = 16'd1;
        writeByte(8'hFF);
        check("postrst latency tx", 32'(tx), 32'd1);
        checkFrame(16'b0111111111, 10, 1, "postrst FF");
        tick();
        check("postrst end busy", 32'(busy), 32'd0);
        $display("reset mid-frame then 0xFF 8N1 at N=1 done");

        // ---------------- simultaneous write/pop ----------------
        cyclesPerBit     = 16'd2;
        blockTransmition = 1'b1;
        writeByte(8'h11);
        writeByte(8'h22);
        blockTransmition = 1'b0;
        dataIn    = 8'h33;
        dataWrite = 1'b1;
        tick();                                     // start edge: pop + write
        check("wrpop count", 32'(fifoCount), 32'd2);
        check("wrpop tx",    32'(tx),        32'd0);
        check("wrpop ovf",   32'(overflow),  32'd0);
        dataIn = 8'h44;
        tick();
        dataIn = 8'h55;
        tick();
        dataWrite = 1'b0;
        check("fill full", 32'(fifoFull), 32'd1);
        repeat (17) tick();
        dataIn    = 8'h66;
        dataWrite = 1'b1;
        tick();                                     // next start edge: pop while full
        dataWrite = 1'b0;
        check("fullpop overflow", 32'(overflow),  32'd1);
        check("fullpop count",    32'(fifoCount), 32'd3);
        check("fullpop fifoFull", 32'(fifoFull),  32'd0);
        for (int i = 0; i < 400 && busy === 1'b1; i++) tick();
        check("drain busy",  32'(busy),      32'd0);
        check("drain count", 32'(fifoCount), 32'd0);
        $display("write/pop same cycle and full-pop drop done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
